// File: rtl/readout_dout_emu_pkg.sv
// Shared definitions for the readout link emulator (Doutb/TransmitOnb side).
// Holds parameter defaults, word/Gray widths and the transmitter state encoding.
package readout_dout_emu_pkg;

  localparam int unsigned CLK_DIV_DEF    = 4;   // Clk cycles per serial bit
  localparam int unsigned GAP_CYCLES_DEF = 8;   // minimum TransmitOnb-high cycles between frames
  localparam int unsigned WORD_W         = 16;  // serial word width
  localparam int unsigned GRAY_W         = 12;  // low bits that travel Gray-encoded

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/readout_dout_emu_bin_2_gray.sv
// Bin_2_Gray: combinational binary-to-Gray converter, the inverse of the
// receiver's Gray_2_Bin.
//   In_Bin   in  GRAY_W  binary value
//   Out_Gray out GRAY_W  Gray-coded value
module readout_dout_emu_bin_2_gray
  import readout_dout_emu_pkg::*;
(
  input  logic [GRAY_W-1:0] In_Bin,
  output logic [GRAY_W-1:0] Out_Gray
);

  always_comb begin
    Out_Gray = In_Bin ^ (In_Bin >> 1);
  end

endmodule

// File: rtl/readout_dout_emu.sv
// readout_dout_emu: serializing transmitter emulating the ASIC end of the
// Doutb/TransmitOnb readout link. Words from a valid/ready source have bits
// [11:0] Gray-encoded, are shifted MSB-first on active-low Doutb at Clk/CLK_DIV
// and framed by active-low TransmitOnb, followed by a guard gap.
//   Clk             in   system clock
//   Rst             in   synchronous active-high reset
//   In_Data         in   16-bit binary word
//   In_Valid        in   In_Data/In_Last valid
//   In_Last         in   final word of a frame
//   Out_Ready       out  word accepted when In_Valid && Out_Ready
//   Out_Doutb       out  serial data, line = ~bit
//   Out_TransmitOnb out  low while a frame is on the line
//   Out_Busy        out  high from first accept until the gap expires
//   Out_Word_Cnt    out  words sent in the current/last frame (saturating)
//   Out_Underrun    out  one-cycle pulse when a frame is cut short for lack of data
module readout_dout_emu
  import readout_dout_emu_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
)(
  input  logic              Clk,
  input  logic              Rst,
  input  logic [WORD_W-1:0] In_Data,
  input  logic              In_Valid,
  input  logic              In_Last,
  output logic              Out_Ready,
  output logic              Out_Doutb,
  output logic              Out_TransmitOnb,
  output logic              Out_Busy,
  output logic [WORD_W-1:0] Out_Word_Cnt,
  output logic              Out_Underrun
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [3:0]          bit_q;
  logic [WORD_W-1:0]   sr_q;
  logic                last_q;
  logic [GAP_W-1:0]    gap_q;
  logic [WORD_W-1:0]   cnt_q;
  logic                ready_q;
  logic                doutb_q;
  logic                txonb_q;
  logic                busy_q;
  logic                underrun_q;

  logic [GRAY_W-1:0]   gray;
  logic [WORD_W-1:0]   tx_word;
  logic                accept;
  logic                div_end;
  logic                pre_boundary;

  readout_dout_emu_bin_2_gray u_bin_2_gray (
    .In_Bin   (In_Data[GRAY_W-1:0]),
    .Out_Gray (gray)
  );

  always_comb begin
    tx_word      = {In_Data[WORD_W-1:GRAY_W], gray};
    accept       = In_Valid && ready_q;
    div_end      = (div_q == DIV_W'(CLK_DIV - 1));
    pre_boundary = (bit_q == 4'd0) && (div_q == DIV_W'(CLK_DIV - 2));
  end

  // The counters run one cycle ahead of the line: the output flops copy the
  // shift register MSB, so Ready is raised one cycle before the last divider
  // cycle of bit 0 and a word taken there lands on the line with no idle cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      last_q     <= 1'b0;
      gap_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      doutb_q    <= 1'b1;
      txonb_q    <= 1'b1;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          doutb_q <= 1'b1;
          txonb_q <= 1'b1;
          if (accept) begin
            sr_q    <= tx_word;
            last_q  <= In_Last;
            bit_q   <= '1;
            div_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            ready_q <= 1'b1;
          end
        end

        ST_SHIFT: begin
          txonb_q <= 1'b0;
          doutb_q <= ~sr_q[WORD_W-1];
          ready_q <= pre_boundary && !last_q;
          if (div_end) begin
            div_q <= '0;
            sr_q  <= {sr_q[WORD_W-2:0], 1'b0};
            bit_q <= bit_q - 4'd1;
            if (bit_q == 4'd0) begin
              if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
              end
              if (last_q) begin
                gap_q   <= '0;
                state_q <= ST_GAP;
              end else if (accept) begin
                sr_q   <= tx_word;
                last_q <= In_Last;
                bit_q  <= '1;
              end else begin
                underrun_q <= 1'b1;
                gap_q      <= '0;
                state_q    <= ST_GAP;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        ST_GAP: begin
          doutb_q <= 1'b1;
          txonb_q <= 1'b1;
          ready_q <= 1'b0;
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Out_Ready       = ready_q;
  assign Out_Doutb       = doutb_q;
  assign Out_TransmitOnb = txonb_q;
  assign Out_Busy        = busy_q;
  assign Out_Word_Cnt    = cnt_q;
  assign Out_Underrun    = underrun_q;

endmodule

// File: tb/tb_readout_dout_emu.sv
// Directed bench for readout_dout_emu: a line monitor rebuilds words from
// Doutb/TransmitOnb as the receiver would (phase-1 sampling) and the main
// sequence compares them against hand-computed Gray words.
module tb_readout_dout_emu;

  localparam int DIV  = 4;
  localparam int GAP  = 8;
  localparam int WCYC = 16 * DIV;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] In_Data = '0;
  logic        In_Valid = 1'b0;
  logic        In_Last = 1'b0;
  logic        Out_Ready;
  logic        Out_Doutb;
  logic        Out_TransmitOnb;
  logic        Out_Busy;
  logic [15:0] Out_Word_Cnt;
  logic        Out_Underrun;

  int checks = 0;
  int errors = 0;

  readout_dout_emu #(
    .CLK_DIV    (DIV),
    .GAP_CYCLES (GAP)
  ) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .In_Data         (In_Data),
    .In_Valid        (In_Valid),
    .In_Last         (In_Last),
    .Out_Ready       (Out_Ready),
    .Out_Doutb       (Out_Doutb),
    .Out_TransmitOnb (Out_TransmitOnb),
    .Out_Busy        (Out_Busy),
    .Out_Word_Cnt    (Out_Word_Cnt),
    .Out_Underrun    (Out_Underrun)
  );

  always #5 Clk = ~Clk;

  // Line monitor, sampled mid-cycle.
  logic [15:0] rx_q[$];
  logic [15:0] sh = '0;
  int  low_run = 0, high_run = 0, last_low_len = 0, frames = 0;
  int  min_gap = 1000000, uf_cnt = 0, bad_ready = 0;
  bit  gap_armed = 0, uf_low_ok = 0, uf_high_next = 0, uf_pend = 0;

  always @(negedge Clk) begin
    if (Rst) begin
      low_run   = 0;
      high_run  = 0;
      gap_armed = 0;
      uf_pend   = 0;
    end else begin
      if (Out_Ready && Out_Busy && Out_TransmitOnb) bad_ready++;
      if (Out_Underrun) begin
        uf_cnt++;
        uf_low_ok = !Out_TransmitOnb;
        uf_pend   = 1;
      end else if (uf_pend) begin
        uf_pend      = 0;
        uf_high_next = Out_TransmitOnb;
      end
      if (!Out_TransmitOnb) begin
        if (low_run == 0) begin
          frames++;
          if (gap_armed && high_run < min_gap) min_gap = high_run;
        end
        if (low_run % DIV == 1) sh = {sh[14:0], ~Out_Doutb};
        if (low_run % WCYC == WCYC - 1) rx_q.push_back(sh);
        low_run++;
        high_run = 0;
      end else begin
        if (low_run != 0) begin
          last_low_len = low_run;
          gap_armed    = 1;
        end
        low_run = 0;
        high_run++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    int n = 0;
    while (!Out_Ready && n < 400) begin
      tick();
      n++;
    end
    check("send_ready", Out_Ready, 1'b1);
    In_Data  = d;
    In_Last  = l;
    In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
    In_Last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Out_Busy && n < 6000) begin
      tick();
      n++;
    end
    check("wait_idle", Out_Busy, 1'b0);
    tick();
  endtask

  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b = g;
    for (int i = 10; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  initial begin
    int base, f0, u0;
    logic [15:0] d;

    // Reset values
    repeat (3) tick();
    check("rst_doutb", Out_Doutb, 1'b1);
    check("rst_txonb", Out_TransmitOnb, 1'b1);
    check("rst_ready", Out_Ready, 1'b0);
    check("rst_busy", Out_Busy, 1'b0);
    check("rst_cnt", Out_Word_Cnt, 16'h0000);
    check("rst_underrun", Out_Underrun, 1'b0);
    Rst = 1'b0;
    tick();
    check("ready_after_rst", Out_Ready, 1'b1);

    // Single word, Last=1
    base = rx_q.size();
    send_word(16'h1005, 1'b1);
    check("t1_busy", Out_Busy, 1'b1);
    check("t1_ready_drop", Out_Ready, 1'b0);
    check("t1_txonb_accept", Out_TransmitOnb, 1'b1);
    tick();
    check("t1_txonb_low", Out_TransmitOnb, 1'b0);
    wait_idle();
    check("t1_nwords", rx_q.size() - base, 1);
    check("t1_word", rx_q[base], 16'h1007);
    check("t1_decode", gray2bin(rx_q[base]), 16'h1005);
    check("t1_lowlen", last_low_len, 64);
    check("t1_cnt", Out_Word_Cnt, 16'd1);

    // Three words back-to-back
    base = rx_q.size();
    send_word(16'h0000, 1'b0);
    send_word(16'h0FFF, 1'b0);
    send_word(16'hF800, 1'b1);
    wait_idle();
    check("t2_nwords", rx_q.size() - base, 3);
    check("t2_w0", rx_q[base], 16'h0000);
    check("t2_w1", rx_q[base+1], 16'h0800);
    check("t2_w2", rx_q[base+2], 16'hFC00);
    check("t2_dec2", gray2bin(rx_q[base+2]), 16'hF800);
    check("t2_lowlen", last_low_len, 192);
    check("t2_cnt", Out_Word_Cnt, 16'd3);

    // Underrun: no second word offered at the boundary
    base = rx_q.size();
    u0   = uf_cnt;
    send_word(16'h3A5C, 1'b0);
    wait_idle();
    check("t3_uf_count", uf_cnt - u0, 1);
    check("t3_uf_in_frame", uf_low_ok, 1'b1);
    check("t3_uf_then_high", uf_high_next, 1'b1);
    check("t3_word", rx_q[base], 16'h3F72);
    check("t3_lowlen", last_low_len, 64);
    check("t3_cnt", Out_Word_Cnt, 16'd1);

    // Reset in the middle of bit 7
    u0 = uf_cnt;
    send_word(16'hFFFF, 1'b1);
    repeat (33) tick();
    check("t4_in_frame", Out_TransmitOnb, 1'b0);
    Rst = 1'b1;
    tick();
    check("t4_doutb", Out_Doutb, 1'b1);
    check("t4_txonb", Out_TransmitOnb, 1'b1);
    check("t4_busy", Out_Busy, 1'b0);
    check("t4_cnt", Out_Word_Cnt, 16'h0000);
    check("t4_ready", Out_Ready, 1'b0);
    Rst = 1'b0;
    tick();
    check("t4_ready_after", Out_Ready, 1'b1);
    check("t4_no_underrun", uf_cnt - u0, 0);

    // In_Valid held high, Last on every word
    base = rx_q.size();
    f0   = frames;
    In_Data  = 16'h0001;
    In_Last  = 1'b1;
    In_Valid = 1'b1;
    for (int n = 0; n < 1000 && frames < f0 + 3; n++) tick();
    In_Valid = 1'b0;
    In_Last  = 1'b0;
    wait_idle();
    check("t5_frames", (frames - f0) >= 3, 1'b1);
    check("t5_words", (rx_q.size() - base) >= 3, 1'b1);
    for (int i = base; i < rx_q.size(); i++) check("t5_word", rx_q[i], 16'h0001);
    check("t5_min_gap", min_gap >= GAP, 1'b1);
    check("t5_ready_in_gap", bad_ready, 0);
    check("t5_cnt", Out_Word_Cnt, 16'd1);

    // Longer frame
    base = rx_q.size();
    for (int i = 0; i < 40; i++) send_word(16'h0100 + 16'(i * 37), i == 39);
    wait_idle();
    check("t6_nwords", rx_q.size() - base, 40);
    check("t6_lowlen", last_low_len, 40 * WCYC);
    check("t6_cnt", Out_Word_Cnt, 16'd40);
    for (int i = 0; i < 40 && base + i < rx_q.size(); i++) begin
      d = 16'h0100 + 16'(i * 37);
      check("t6_decode", gray2bin(rx_q[base+i]), d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
